// File: rtl/sync_fifo_if.sv
// sync_fifo_if: FIFO bus between a driver (master) and the sync_fifo (slave).
// Carries chip-select, write/read enables, write data, registered read data,
// occupancy and status/error flags.
interface sync_fifo_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              cs;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   modport master (
      output cs, wr_en, rd_en, data_in,
      input  data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  cs, wr_en, rd_en, data_in,
      output data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and optional sticky error flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the overflow/underflow registers;
// without it both flags are tied low. Every output comes from a register.
module sync_fifo #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input logic        clk,
   input logic        rst,
   sync_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_nxt;
   logic [DATA_W-1:0] dout_q;
   logic              full_q;
   logic              empty_q;
   logic              af_q;
   logic              ae_q;
   logic              wr_acc;
   logic              rd_acc;

   // A read needs data; a write needs room, or a read freeing a slot this edge.
   assign rd_acc = bus.cs & bus.rd_en & ~empty_q;
   assign wr_acc = bus.cs & bus.wr_en & (~full_q | rd_acc);

   // Next occupancy: moves only when exactly one side is accepted.
   always_comb begin
      // NOTE: default assignment first so every path drives count_nxt; otherwise a latch is inferred.
      count_nxt = count_q;
      if (wr_acc && !rd_acc) begin
         count_nxt = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count_q - CNT_W'(1);
      end
   end

   // Storage array: written on every accepted write.
   // NOTE: the array has no reset so it can map onto RAM; no location is read before it has been written.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wptr] <= bus.data_in;
      end
   end

   // Pointers, occupancy, read data and status flags; flags follow count_nxt so they move with count.
   // When full with a simultaneous write and read, wptr == rptr and the read still sees the old word.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
         dout_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (rd_acc) begin
            rptr   <= rptr + PTR_W'(1);
            dout_q <= mem[rptr];
         end
         count_q <= count_nxt;
         full_q  <= (count_nxt == FULL_CNT);
         empty_q <= (count_nxt == '0);
         af_q    <= (count_nxt >= AF_CNT);
         ae_q    <= (count_nxt <= AE_CNT);
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   // Sticky error flags: a dropped write or a read of an empty FIFO, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.cs && bus.wr_en && full_q && !rd_acc) begin
            overflow_q <= 1'b1;
         end
         if (bus.cs && bus.rd_en && empty_q) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif

   assign bus.data_out     = dout_q;
   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed stimulus for sync_fifo. The stimulus
// process updates a queue-based reference FIFO and pushes the expected output
// snapshot for the coming edge into a scoreboard; a separate monitor pops and
// compares it against the DUT 3 time units before the following edge.
module tb_sync_fifo;
   localparam int DATA_W   = 32;
   localparam int DEPTH    = 16;
   localparam int CNT_W    = $clog2(DEPTH) + 1;
   localparam int AF_LEVEL = DEPTH - 2;
   localparam int AE_LEVEL = 2;

   // Expected DUT state after edge number edge_no.
   typedef struct {
      int unsigned       edge_no;
      logic [DATA_W-1:0] data_out;
      logic [CNT_W-1:0]  count;
      logic [5:0]        flags;   // full, empty, almost_full, almost_empty, overflow, underflow
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   sync_fifo #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .AF_LEVEL(AF_LEVEL),
      .AE_LEVEL(AE_LEVEL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #10 clk = ~clk;

   int unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   int checks = 0;
   int errors = 0;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] model_q[$];
   logic [DATA_W-1:0] model_dout = '0;
   logic              model_ovf  = 1'b0;
   logic              model_unf  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_cnt, act, exp);
      end
   endtask

   function automatic exp_t snapshot(input int unsigned e);
      exp_t x;
      int   n;
      n          = model_q.size();
      x.edge_no  = e;
      x.data_out = model_dout;
      x.count    = CNT_W'(n);
      x.flags    = {n == DEPTH, n == 0, n >= AF_LEVEL, n <= AE_LEVEL, model_ovf, model_unf};
      return x;
   endfunction

   // One clock of stimulus: drive 1 unit after an edge, update the reference
   // FIFO as of the next edge and queue the expected result. rs asserts reset
   // late in the cycle (after the monitor has sampled) to exercise async reset.
   task automatic cycle(input logic c, input logic w, input logic r,
                        input logic [DATA_W-1:0] d, input logic rs = 1'b0);
      logic rd_ok;
      logic wr_ok;
      @(posedge clk);
      #1;
      bus.cs      = c;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.data_in = d;
      if (rs) begin
         model_q.delete();
         model_dout = '0;
         model_ovf  = 1'b0;
         model_unf  = 1'b0;
         if (!rst) begin
            #17;
            rst = 1'b1;
            #1;
            check("async_rst_count", bus.count, '0);
            check("async_rst_empty", bus.empty, 1'b1);
         end
      end else begin
         rst   = 1'b0;
         rd_ok = c && r && (model_q.size() != 0);
         wr_ok = c && w && ((model_q.size() < DEPTH) || rd_ok);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
         if (c && r && model_q.size() == 0) model_unf = 1'b1;
         if (c && w && !wr_ok)              model_ovf = 1'b1;
`endif
         if (rd_ok) model_dout = model_q.pop_front();
         if (wr_ok) model_q.push_back(d);
      end
      exp_q.push_back(snapshot(edge_cnt + 1));
   endtask

   task automatic wr(input logic [DATA_W-1:0] d);
      cycle(1'b1, 1'b1, 1'b0, d);
   endtask

   task automatic rd();
      cycle(1'b1, 1'b0, 1'b1, '0);
   endtask

   // Monitor: compare the DUT against the snapshot queued for this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #17;
         while (exp_q.size() != 0 && exp_q[0].edge_no == edge_cnt) begin
            e = exp_q.pop_front();
            check("data_out", bus.data_out, e.data_out);
            check("count", bus.count, e.count);
            check("flags{full,empty,af,ae,ovf,unf}",
                  {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                   bus.overflow, bus.underflow}, e.flags);
         end
      end
   end

   // Stimulus.
   initial begin
      int wr_pct;
      bus.cs      = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = '0;

      // Reset held, then deselected activity must be ignored.
      repeat (2) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
      repeat (5) cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);

      // Fill with 1..16, drain in order.
      for (int i = 1; i <= DEPTH; i++) wr(DATA_W'(i));
      repeat (DEPTH) rd();

      // Overflow: extra write while full is dropped.
      repeat (DEPTH) wr($urandom());
      wr(32'hDEAD);
      repeat (DEPTH) rd();

      // Full with simultaneous write and read.
      repeat (DEPTH) wr($urandom());
      cycle(1'b1, 1'b1, 1'b1, 32'hBEEF);
      repeat (DEPTH) rd();

      // Empty with simultaneous write and read: no bypass.
      cycle(1'b1, 1'b1, 1'b1, 32'hA5);
      rd();
      rd();

      // Interleaved traffic to wrap both pointers.
      for (int i = 0; i < 24; i++) begin
         wr($urandom());
         rd();
      end

      // Randomized traffic, phases biased toward filling then draining.
      for (int i = 0; i < 320; i++) begin
         wr_pct = ((i / 40) % 2 == 0) ? 75 : 25;
         cycle(($urandom() % 8) != 0, ($urandom() % 100) < wr_pct,
               ($urandom() % 100) >= wr_pct, $urandom());
      end

      // Drain, then a burst interrupted by reset, then fresh traffic.
      repeat (DEPTH + 1) rd();
      repeat (5) wr($urandom());
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
      wr(32'h1234_5678);
      wr(32'h0BAD_CAFE);
      rd();
      rd();
      cycle(1'b0, 1'b0, 1'b0, '0);

      repeat (3) @(posedge clk);
      #5;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
